// File: rtl/map_pkg.sv
// Geometry of the 160x90 map-index RAM, shared by the painter and the renderer.
package map_pkg;
  localparam int MAP_WIDTH  = 160;
  localparam int MAP_HEIGHT = 90;
  localparam int MAP_ADDR_W = 14;
  localparam int MAP_PIX_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PAINT = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } painter_state_t;
endpackage

// File: rtl/map_box_clip.sv
// Clips a square brush to the map, registering its bounds and first-row base address.
module map_box_clip
  import map_pkg::*;
#(
  parameter int WIDTH  = MAP_WIDTH,
  parameter int HEIGHT = MAP_HEIGHT,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int R_W    = 3,
  parameter int ADDR_W = MAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_in,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [R_W-1:0]    r_in,
  output logic [X_W-1:0]    x0_out,
  output logic [X_W-1:0]    x1_out,
  output logic [Y_W-1:0]    y0_out,
  output logic [Y_W-1:0]    y1_out,
  output logic [ADDR_W-1:0] row_base_out,
  output logic              out_of_range_out
);
  logic [X_W:0]      x_hi_s;
  logic [Y_W:0]      y_hi_s;
  logic [X_W-1:0]    x0_s, x1_s, x0_d, x1_d, x0_q, x1_q;
  logic [Y_W-1:0]    y0_s, y1_s, y0_d, y1_d, y0_q, y1_q;
  logic [ADDR_W-1:0] row_base_d, row_base_q;

  // The centre check is needed in the same cycle the bounds are captured, so it stays combinational.
  assign out_of_range_out = ({1'b0, x_in} >= (X_W+1)'(WIDTH)) || ({1'b0, y_in} >= (Y_W+1)'(HEIGHT));

  always_comb begin
    x_hi_s = {1'b0, x_in} + (X_W+1)'(r_in);
    y_hi_s = {1'b0, y_in} + (Y_W+1)'(r_in);
    if ({1'b0, x_in} >= (X_W+1)'(r_in)) x0_s = x_in - X_W'(r_in);
    else                                x0_s = {X_W{1'b0}};
    if ({1'b0, y_in} >= (Y_W+1)'(r_in)) y0_s = y_in - Y_W'(r_in);
    else                                y0_s = {Y_W{1'b0}};
    if (x_hi_s > (X_W+1)'(WIDTH-1))  x1_s = X_W'(WIDTH-1);
    else                             x1_s = x_hi_s[X_W-1:0];
    if (y_hi_s > (Y_W+1)'(HEIGHT-1)) y1_s = Y_W'(HEIGHT-1);
    else                             y1_s = y_hi_s[Y_W-1:0];
    if (load_in) begin
      x0_d       = x0_s;
      x1_d       = x1_s;
      y0_d       = y0_s;
      y1_d       = y1_s;
      row_base_d = ADDR_W'(y0_s) * ADDR_W'(WIDTH);
    end else begin
      x0_d       = x0_q;
      x1_d       = x1_q;
      y0_d       = y0_q;
      y1_d       = y1_q;
      row_base_d = row_base_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q       <= {X_W{1'b0}};
      x1_q       <= {X_W{1'b0}};
      y0_q       <= {Y_W{1'b0}};
      y1_q       <= {Y_W{1'b0}};
      row_base_q <= {ADDR_W{1'b0}};
    end else begin
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      row_base_q <= row_base_d;
    end
  end

  assign x0_out       = x0_q;
  assign x1_out       = x1_q;
  assign y0_out       = y0_q;
  assign y1_out       = y1_q;
  assign row_base_out = row_base_q;
endmodule

// File: rtl/map_painter.sv
// Write-side engine for the map-index RAM: clipped square-brush paints and whole-map
// clears, one write per clock on the RAM write port.
module map_painter
  import map_pkg::*;
#(
  parameter int WIDTH      = MAP_WIDTH,
  parameter int HEIGHT     = MAP_HEIGHT,
  parameter int MAX_RADIUS = 7,
  parameter int ADDR_W     = $clog2(WIDTH*HEIGHT),
  parameter int RAD_W      = $clog2(MAX_RADIUS+1)
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [7:0]           req_x_in,
  input  logic [6:0]           req_y_in,
  input  logic [RAD_W-1:0]     req_radius_in,
  input  logic [MAP_PIX_W-1:0] req_color_in,
  input  logic                 clear_in,
  input  logic [MAP_PIX_W-1:0] clear_color_in,
  output logic                 wr_en_out,
  output logic [ADDR_W-1:0]    wr_addr_out,
  output logic [MAP_PIX_W-1:0] wr_data_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [ADDR_W-1:0]    count_out
);
  localparam int CELLS = WIDTH * HEIGHT;

  painter_state_t       state_q, state_d;
  logic [7:0]           x_q, x_d, col_q, col_d;
  logic [6:0]           y_q, y_d, row_q, row_d;
  logic [RAD_W-1:0]     r_q, r_d;
  logic [MAP_PIX_W-1:0] color_q, color_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]    row_off_q, row_off_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d, count_q, count_d;
  logic                 pend_q, pend_d, wr_en_q, wr_en_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic [7:0]           x0_s, x1_s;
  logic [6:0]           y0_s, y1_s;
  logic [ADDR_W-1:0]    row_base_s;
  logic                 oor_s, accept_s, clear_go_s, row_end_s, box_end_s, clear_end_s;

  map_box_clip #(
    .WIDTH (WIDTH), .HEIGHT(HEIGHT), .X_W(8), .Y_W(7), .R_W(RAD_W), .ADDR_W(ADDR_W)
  ) u_clip (
    .clk             (pixel_clk_in),
    .rst             (rst_in),
    .load_in         (state_q == ST_SETUP),
    .x_in            (x_q),
    .y_in            (y_q),
    .r_in            (r_q),
    .x0_out          (x0_s),
    .x1_out          (x1_s),
    .y0_out          (y0_s),
    .y1_out          (y1_s),
    .row_base_out    (row_base_s),
    .out_of_range_out(oor_s)
  );

  // A clear (fresh or pending) outranks a paint, so ready drops while one is waiting.
  assign req_ready_out = (state_q == ST_IDLE) && !clear_in && !pend_q;
  assign accept_s      = req_valid_in && req_ready_out;
  assign clear_go_s    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (clear_in || pend_q);
  assign row_end_s     = (x0_s + col_q) == x1_s;
  assign box_end_s     = row_end_s && ((y0_s + row_q) == y1_s);
  assign clear_end_s   = cnt_q == ADDR_W'(CELLS-1);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_go_s)    state_d = ST_CLEAR;
        else if (accept_s) state_d = ST_SETUP;
        else               state_d = ST_IDLE;
      end
      ST_SETUP: begin
        if (oor_s) state_d = ST_DONE;
        else       state_d = ST_PAINT;
      end
      ST_PAINT: begin
        if (box_end_s) state_d = ST_DONE;
        else           state_d = ST_PAINT;
      end
      ST_CLEAR: begin
        if (clear_end_s) state_d = ST_DONE;
        else             state_d = ST_CLEAR;
      end
      ST_DONE: begin
        if (clear_go_s) state_d = ST_CLEAR;
        else            state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d = x_q;  y_d = y_q;  r_d = r_q;  color_d = color_q;
    col_d = col_q;  row_d = row_q;  row_off_d = row_off_q;  cnt_d = cnt_q;
    wr_en_d = 1'b0;  wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;
    done_d = 1'b0;  count_d = count_q;
    busy_d = (state_d != ST_IDLE);
    if (clear_go_s)                          pend_d = 1'b0;
    else if (clear_in && state_q != ST_IDLE) pend_d = 1'b1;
    else                                     pend_d = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_go_s) begin
          color_d = clear_color_in;
          cnt_d   = {ADDR_W{1'b0}};
        end else if (accept_s) begin
          x_d = req_x_in;  y_d = req_y_in;  r_d = req_radius_in;
          color_d = req_color_in;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SETUP: begin
        col_d = 8'd0;  row_d = 7'd0;  row_off_d = {ADDR_W{1'b0}};
      end
      ST_PAINT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_base_s + row_off_q + ADDR_W'(x0_s) + ADDR_W'(col_q);
        wr_data_d = color_q;
        cnt_d     = cnt_q + 1'b1;
        // Row advance is an add of WIDTH; the only multiply lives in the clip stage.
        if (row_end_s) begin
          col_d     = 8'd0;
          row_d     = row_q + 7'd1;
          row_off_d = row_off_q + ADDR_W'(WIDTH);
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = color_q;
        cnt_d     = cnt_q + 1'b1;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        count_d = cnt_q;
        if (clear_go_s) begin
          color_d = clear_color_in;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      x_q <= 8'd0;  y_q <= 7'd0;  r_q <= {RAD_W{1'b0}};  color_q <= {MAP_PIX_W{1'b0}};
      col_q <= 8'd0;  row_q <= 7'd0;  row_off_q <= {ADDR_W{1'b0}};  cnt_q <= {ADDR_W{1'b0}};
      pend_q <= 1'b0;  wr_en_q <= 1'b0;  wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {MAP_PIX_W{1'b0}};  busy_q <= 1'b0;  done_q <= 1'b0;
      count_q <= {ADDR_W{1'b0}};
    end else begin
      x_q <= x_d;  y_q <= y_d;  r_q <= r_d;  color_q <= color_d;
      col_q <= col_d;  row_q <= row_d;  row_off_q <= row_off_d;  cnt_q <= cnt_d;
      pend_q <= pend_d;  wr_en_q <= wr_en_d;  wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;  busy_q <= busy_d;  done_q <= done_d;
      count_q <= count_d;
    end
  end

  assign wr_en_out   = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign count_out   = count_q;
endmodule

// File: doc/map_painter.md
# map_painter

Write-side engine for the 160×90 4-bit map-index RAM that the perspective map renderer reads every pixel. It accepts square-brush paint requests and whole-map clear commands, clips each to the map bounds and issues one RAM write per clock on the write port of a dual-port map RAM, leaving the renderer's read port untouched. It sits between game logic (ball trail, editor controls) and the map RAM.

## Interface
Parameters:
- WIDTH, 160, map width in cells
- HEIGHT, 90, map height in cells
- MAX_RADIUS, 7, largest accepted brush radius; `req_radius_in` width is clog2(MAX_RADIUS+1)
- ADDR_W, clog2(WIDTH*HEIGHT) = 14, write address width

Ports:
- pixel_clk_in  in  1  sole clock
- rst_in  in  1  reset, synchronous, active-high
- req_valid_in  in  1  paint request valid
- req_ready_out  out  1  high only in IDLE
- req_x_in  in  8  brush centre x, map cells
- req_y_in  in  7  brush centre y, map cells
- req_radius_in  in  3  brush half-size r; box is (2r+1)×(2r+1)
- req_color_in  in  4  palette index to write
- clear_in  in  1  clear command, one-cycle pulse
- clear_color_in  in  4  index written by clear
- wr_en_out  out  1  map RAM write enable
- wr_addr_out  out  ADDR_W  y*WIDTH + x
- wr_data_out  out  4  index written
- busy_out  out  1  high in any non-IDLE state
- done_out  out  1  one-cycle pulse at end of every operation
- count_out  out  14  writes issued by the last completed operation

## Operation
- States: IDLE, SETUP, PAINT, CLEAR, DONE.
- IDLE: handshake is `req_valid_in && req_ready_out`; request fields latched on that edge, then go to SETUP. A `clear_in` in IDLE (or a pending clear) goes to CLEAR. If clear and paint arrive together, clear wins and the paint stays unaccepted, because ready drops.
- SETUP, one cycle:
  - x0 = max(0, x−r), x1 = min(WIDTH−1, x+r); y0 and y1 likewise against HEIGHT−1. Use unsigned-safe compare, never negative wrap.
  - If x ≥ WIDTH or y ≥ HEIGHT, go to DONE with zero writes.
  - Otherwise load row base = y0*WIDTH, using the only multiply, and go to PAINT.
- PAINT: row-major walk from (x0,y0) to (x1,y1), one write per cycle. The column increments the address; at the end of a row, row base += WIDTH. No per-pixel multiply. Go to DONE after (x1,y1).
- CLEAR: addresses 0 … WIDTH*HEIGHT−1 in order with clear_color_in, which is latched at entry. Go to DONE after the last address.
- DONE: `done_out`=1, `count_out` updated, then IDLE.
- `clear_in` while busy sets a pending flag; the clear runs immediately after the current DONE. Multiple pulses collapse into one.
- `count_out` holds its value until the next DONE.
- Reset value of every output:
  - `wr_en_out`=0, `wr_addr_out`=0, `wr_data_out`=0, `busy_out`=0, `done_out`=0, `count_out`=0.
  - `req_ready_out`=1, because the FSM is in IDLE.
  - The pending flag clears.
- Reset mid-operation aborts immediately: no further writes, no done pulse.

## Timing
- All outputs registered except `req_ready_out`, which decodes from state.
- Paint accepted at edge T, box of n cells:
  - Writes on cycles T+2 … T+n+1, back to back.
  - `done_out` at T+n+2; ready high from T+n+2.
- Out-of-range paint: zero writes, `done_out` at T+2.
- Clear seen at edge C: writes on C+1 … C+WIDTH*HEIGHT; `done_out` at C+WIDTH*HEIGHT+1.
- The RAM write port samples `wr_en/addr/data` on the same edge, with no additional latency.

## Structure
- Shared package `map_pkg`:
  - MAP_WIDTH=160, MAP_HEIGHT=90, MAP_ADDR_W=14, MAP_PIX_W=4 (also used by the renderer).
  - `painter_state_t` enum.
- One natural sub-module: `map_box_clip`, registered in SETUP. Inputs are centre, radius and bounds; outputs are x0, x1, y0, y1, row base and out_of_range.

## Test plan
- Paint (10,5) r=1 c=3 → 9 writes, addrs 649,650,651,809,810,811,969,970,971, data 3; `done_out` at T+11, `count_out`=9.
- Paint (0,0) r=2 → clipped to 9 writes: 0,1,2,160,161,162,320,321,322.
- Paint (159,89) r=1 → 4 writes: 14238,14239,14398,14399.
- Paint x=160 → no `wr_en_out`, `done_out` at T+2, `count_out`=0.
- `clear_in` c=0 from IDLE → 14400 consecutive writes 0…14399, `done_out`, `count_out`=14400. `clear_in` pulsed twice mid-paint → paint completes, then exactly one clear runs.
- `rst_in` at write 500 of a clear → `wr_en_out`=0 the next cycle, `busy_out`=0, no `done_out`, ready=1. A `req_valid_in` held through a busy period is accepted only once, at return to IDLE.
